// File: rtl/krnl_proj_split_hls_deadlock_report.sv
// Persistence filter on the dataflow monitor's block output for krnl_proj_split.
// Declares a sticky deadlock with a report pulse, input snapshots and saturating debug counters.
module krnl_proj_split_hls_deadlock_report #(
  parameter int unsigned THRESHOLD = 1024,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned EVT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             block,
  input  logic [2:0]       axis_block_sigs,
  input  logic [8:0]       inst_idle_sigs,
  input  logic [4:0]       inst_block_sigs,
  input  logic             clear,
  output logic             deadlock,
  output logic             report,
  output logic [2:0]       snap_axis,
  output logic [8:0]       snap_idle,
  output logic [4:0]       snap_block,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [EVT_W-1:0] event_count
);

  localparam logic [CNT_W-1:0] THR = CNT_W'(THRESHOLD);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] pcnt_inc;
  logic             decl;

  logic             deadlock_q, deadlock_d;
  logic             report_q, report_d;
  logic [2:0]       snap_axis_q, snap_axis_d;
  logic [8:0]       snap_idle_q, snap_idle_d;
  logic [4:0]       snap_block_q, snap_block_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [EVT_W-1:0] evt_q, evt_d;
  logic             run_q, run_d;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [EVT_W-1:0] sat_inc_evt(input logic [EVT_W-1:0] v);
    return (&v) ? v : v + EVT_W'(1);
  endfunction

  assign pcnt_inc = pcnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    decl    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (block) begin
          pcnt_d = CNT_W'(1);
          if (THR == CNT_W'(1)) begin
            state_d = S_LOCKED;
            decl    = 1'b1;
          end else begin
            state_d = S_ARMED;
          end
        end
      end
      S_ARMED: begin
        if (block) begin
          pcnt_d = pcnt_inc;
          if (pcnt_inc == THR) begin
            state_d = S_LOCKED;
            decl    = 1'b1;
          end
        end else begin
          pcnt_d  = '0;
          state_d = S_IDLE;
        end
      end
      S_LOCKED: begin
        if (!block) begin
          pcnt_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        pcnt_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Clear zeroes status first; a coincident declaration then overrides it,
  // so the event count restarts at 1 rather than being lost.
  always_comb begin
    deadlock_d   = deadlock_q;
    snap_axis_d  = snap_axis_q;
    snap_idle_d  = snap_idle_q;
    snap_block_d = snap_block_q;
    stall_d      = stall_q;
    evt_d        = evt_q;
    run_d        = run_q;
    report_d     = decl;
    if (clear) begin
      deadlock_d   = 1'b0;
      snap_axis_d  = '0;
      snap_idle_d  = '0;
      snap_block_d = '0;
      stall_d      = '0;
      evt_d        = '0;
      run_d        = 1'b0;
    end else if (state_q == S_LOCKED && block && run_q) begin
      stall_d = sat_inc_cnt(stall_q);
    end
    if (decl) begin
      deadlock_d   = 1'b1;
      snap_axis_d  = axis_block_sigs;
      snap_idle_d  = inst_idle_sigs;
      snap_block_d = inst_block_sigs;
      stall_d      = THR;
      evt_d        = sat_inc_evt(evt_d);
      run_d        = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pcnt_q       <= '0;
      deadlock_q   <= 1'b0;
      report_q     <= 1'b0;
      snap_axis_q  <= '0;
      snap_idle_q  <= '0;
      snap_block_q <= '0;
      stall_q      <= '0;
      evt_q        <= '0;
      run_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pcnt_q       <= pcnt_d;
      deadlock_q   <= deadlock_d;
      report_q     <= report_d;
      snap_axis_q  <= snap_axis_d;
      snap_idle_q  <= snap_idle_d;
      snap_block_q <= snap_block_d;
      stall_q      <= stall_d;
      evt_q        <= evt_d;
      run_q        <= run_d;
    end
  end

  assign deadlock     = deadlock_q;
  assign report       = report_q;
  assign snap_axis    = snap_axis_q;
  assign snap_idle    = snap_idle_q;
  assign snap_block   = snap_block_q;
  assign stall_cycles = stall_q;
  assign event_count  = evt_q;

endmodule

// File: tb/tb_krnl_proj_split_hls_deadlock_report.sv
// Directed bench: THRESHOLD=4 instance driven from a vector table, plus a
// CNT_W=4/THRESHOLD=15 instance for saturation and asynchronous reset.
module tb_krnl_proj_split_hls_deadlock_report;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        block, clear;
  logic [2:0]  axis_i;
  logic [8:0]  idle_i;
  logic [4:0]  blk_i;
  logic        deadlock, report;
  logic [2:0]  snap_axis;
  logic [8:0]  snap_idle;
  logic [4:0]  snap_block;
  logic [31:0] stall_cycles;
  logic [15:0] event_count;

  logic        block_s, clear_s;
  logic        deadlock_s, report_s;
  logic [2:0]  snap_axis_s;
  logic [8:0]  snap_idle_s;
  logic [4:0]  snap_block_s;
  logic [3:0]  stall_s;
  logic [15:0] event_s;

  krnl_proj_split_hls_deadlock_report #(.THRESHOLD(4), .CNT_W(32), .EVT_W(16)) dut (
    .clock(clock), .reset(reset), .block(block),
    .axis_block_sigs(axis_i), .inst_idle_sigs(idle_i), .inst_block_sigs(blk_i),
    .clear(clear), .deadlock(deadlock), .report(report),
    .snap_axis(snap_axis), .snap_idle(snap_idle), .snap_block(snap_block),
    .stall_cycles(stall_cycles), .event_count(event_count)
  );

  krnl_proj_split_hls_deadlock_report #(.THRESHOLD(15), .CNT_W(4), .EVT_W(16)) dut_s (
    .clock(clock), .reset(reset), .block(block_s),
    .axis_block_sigs(3'b101), .inst_idle_sigs(9'h055), .inst_block_sigs(5'b00011),
    .clear(clear_s), .deadlock(deadlock_s), .report(report_s),
    .snap_axis(snap_axis_s), .snap_idle(snap_idle_s), .snap_block(snap_block_s),
    .stall_cycles(stall_s), .event_count(event_s)
  );

  typedef struct {
    logic        blk;
    logic        clr;
    logic [4:0]  ib;
    logic [2:0]  ax;
    logic [8:0]  idl;
    logic        e_dl;
    logic        e_rpt;
    logic [15:0] e_evt;
    logic [31:0] e_stall;
    logic [4:0]  e_sb;
    logic [2:0]  e_sa;
    logic [8:0]  e_si;
  } vec_t;

  vec_t vq[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%0h want=%0h", name, idx, act, exp);
    end
  endtask

  task automatic row(input logic b, input logic c, input logic [4:0] ib, input logic [2:0] ax,
                     input logic [8:0] idl, input logic dl, input logic rpt, input logic [15:0] evt,
                     input logic [31:0] st, input logic [4:0] sb, input logic [2:0] sa,
                     input logic [8:0] si);
    vec_t v;
    v.blk = b; v.clr = c; v.ib = ib; v.ax = ax; v.idl = idl;
    v.e_dl = dl; v.e_rpt = rpt; v.e_evt = evt; v.e_stall = st;
    v.e_sb = sb; v.e_sa = sa; v.e_si = si;
    vq.push_back(v);
  endtask

  initial begin
    logic [4:0] ib1, ib2, ib3;
    logic [2:0] ax1, ax2, ax3;
    logic [8:0] id1, id2, id3;
    ib1 = 5'b10110; ax1 = 3'b001; id1 = 9'h0F0;
    ib2 = 5'b01001; ax2 = 3'b110; id2 = 9'h10F;
    ib3 = 5'b11111; ax3 = 3'b111; id3 = 9'h1FF;

    // Transient stalls shorter than the threshold never declare.
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 3; k++) row(1, 0, ib1, ax1, id1, 0, 0, 0, 0, 0, 0, 0);
      row(0, 0, ib1, ax1, id1, 0, 0, 0, 0, 0, 0, 0);
    end
    // First declaration on the 4th edge, then stall counting.
    for (int k = 0; k < 3; k++) row(1, 0, ib1, ax1, id1, 0, 0, 0, 0, 0, 0, 0);
    row(1, 0, ib1, ax1, id1, 1, 1, 1, 4, ib1, ax1, id1);
    for (int k = 5; k <= 10; k++) row(1, 0, ib1, ax1, id1, 1, 0, 1, k, ib1, ax1, id1);
    row(0, 0, ib1, ax1, id1, 1, 0, 1, 10, ib1, ax1, id1);
    // Second declaration overwrites snapshots and stall count.
    for (int k = 0; k < 3; k++) row(1, 0, ib2, ax2, id2, 1, 0, 1, 10, ib1, ax1, id1);
    row(1, 0, ib2, ax2, id2, 1, 1, 2, 4, ib2, ax2, id2);
    row(1, 0, ib2, ax2, id2, 1, 0, 2, 5, ib2, ax2, id2);
    // Clear while locked: status zeroed, stays locked, no re-declaration.
    row(1, 1, ib2, ax2, id2, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) row(1, 0, ib2, ax2, id2, 0, 0, 0, 0, 0, 0, 0);
    row(0, 0, ib2, ax2, id2, 0, 0, 0, 0, 0, 0, 0);
    // Clear coincident with a declaration edge.
    for (int k = 0; k < 3; k++) row(1, 0, ib3, ax3, id3, 0, 0, 0, 0, 0, 0, 0);
    row(1, 1, ib3, ax3, id3, 1, 1, 1, 4, ib3, ax3, id3);
    row(0, 0, ib3, ax3, id3, 1, 0, 1, 4, ib3, ax3, id3);

    block = 0; clear = 0; axis_i = 0; idle_i = 0; blk_i = 0;
    block_s = 0; clear_s = 0;

    #2;
    check("rst_deadlock", -1, {31'd0, deadlock}, 0);
    check("rst_report",   -1, {31'd0, report}, 0);
    check("rst_stall",    -1, stall_cycles, 0);
    check("rst_event",    -1, {16'd0, event_count}, 0);
    check("rst_snaps",    -1, {15'd0, snap_block, snap_axis, snap_idle}, 0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 0;
    check("rst_hold_deadlock", -1, {31'd0, deadlock}, 0);

    foreach (vq[i]) begin
      block = vq[i].blk; clear = vq[i].clr;
      blk_i = vq[i].ib; axis_i = vq[i].ax; idle_i = vq[i].idl;
      @(posedge clock); #1;
      check("deadlock",   i, {31'd0, deadlock}, {31'd0, vq[i].e_dl});
      check("report",     i, {31'd0, report}, {31'd0, vq[i].e_rpt});
      check("event",      i, {16'd0, event_count}, {16'd0, vq[i].e_evt});
      check("stall",      i, stall_cycles, vq[i].e_stall);
      check("snap_block", i, {27'd0, snap_block}, {27'd0, vq[i].e_sb});
      check("snap_axis",  i, {29'd0, snap_axis}, {29'd0, vq[i].e_sa});
      check("snap_idle",  i, {23'd0, snap_idle}, {23'd0, vq[i].e_si});
    end
    block = 0; clear = 0;

    // Narrow counter instance: declare at 15, stall count already saturated.
    block_s = 1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock); #1;
      if (i == 14) check("sat_pre_deadlock", i, {31'd0, deadlock_s}, 0);
      if (i == 15) begin
        check("sat_decl_deadlock", i, {31'd0, deadlock_s}, 1);
        check("sat_decl_report",   i, {31'd0, report_s}, 1);
        check("sat_decl_stall",    i, {28'd0, stall_s}, 15);
        check("sat_decl_snap",     i, {15'd0, snap_block_s, snap_axis_s, snap_idle_s}, {15'd0, 5'b00011, 3'b101, 9'h055});
      end
      if (i == 16) begin
        check("sat_report_low", i, {31'd0, report_s}, 0);
        check("sat_stall_16",   i, {28'd0, stall_s}, 15);
      end
      if (i == 40) begin
        check("sat_stall_40", i, {28'd0, stall_s}, 15);
        check("sat_event_40", i, {16'd0, event_s}, 1);
      end
    end

    // Asynchronous reset mid-stall, checked well before the next edge.
    #1 reset = 1;
    #1;
    check("arst_deadlock_s", -1, {31'd0, deadlock_s}, 0);
    check("arst_stall_s",    -1, {28'd0, stall_s}, 0);
    check("arst_event_s",    -1, {16'd0, event_s}, 0);
    check("arst_snaps_s",    -1, {15'd0, snap_block_s, snap_axis_s, snap_idle_s}, 0);
    check("arst_deadlock",   -1, {31'd0, deadlock}, 0);
    check("arst_event",      -1, {16'd0, event_count}, 0);
    check("arst_stall",      -1, stall_cycles, 0);
    #2 reset = 0;
    block_s = 0;
    @(posedge clock); #1;
    check("post_rst_deadlock_s", -1, {31'd0, deadlock_s}, 0);
    check("post_rst_report_s",   -1, {31'd0, report_s}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
